// File: rtl/jpeg_pkg.sv
// Constants and types shared by the JPEG coefficient reorder blocks.
// ZIGZAG_TO_RASTER[k] is the raster index (row*8+col) of zigzag position k.
package jpeg_pkg;

  localparam int BLOCK_SIZE = 64;

  localparam logic [5:0] ZIGZAG_TO_RASTER [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [5:0] pos;
  } dctPort_t;

endpackage

// File: rtl/izz_bank_ram.sv
// Two 64-entry coefficient banks in one array; address bit 6 selects the bank.
// One write port and one registered read port; only the read register is reset.
module izz_bank_ram #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [6:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [6:0]            raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [128];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/izigzag_buffer.sv
// Inverse zigzag reorder: zigzag-ordered blocks in, raster-ordered blocks out,
// double-buffered so a new block can be written while the previous one is read.
module izigzag_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [5:0]            out_pos,
  output logic                  out_last
);

  import jpeg_pkg::ZIGZAG_TO_RASTER;
  import jpeg_pkg::dctPort_t;

  localparam logic [5:0] LAST_POS = 6'(BLOCK_SIZE - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_READ  = 1'b1;

  logic [5:0] wr_k_q, wr_k_d;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] pending_q, pending_d;
  logic [0:0] state_q, state_d;
  logic [5:0] rd_pos_q, rd_pos_d;
  logic       rd_bank_q, rd_bank_d;
  dctPort_t   out_q, out_d;

  logic       wr_en_s, wr_done_s, rd_en_s;
  logic [1:0] pending_set_s, pending_clr_s, other_mask_s;
  logic [6:0] waddr_s, raddr_s;

  // Write side: zigzag counter and bank hand-over
  always_comb begin
    wr_en_s       = in_valid && !rst;
    wr_done_s     = wr_en_s && (wr_k_q == LAST_POS);
    wr_k_d        = wr_en_s ? (wr_k_q + 6'd1) : wr_k_q;
    wr_bank_d     = wr_done_s ? ~wr_bank_q : wr_bank_q;
    pending_set_s = wr_done_s ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    waddr_s       = {wr_bank_q, ZIGZAG_TO_RASTER[wr_k_q]};
  end

  // Read FSM; a hand-over landing on the final read edge is seen via pending_set_s
  always_comb begin
    state_d       = state_q;
    rd_pos_d      = rd_pos_q;
    rd_bank_d     = rd_bank_q;
    rd_en_s       = 1'b0;
    pending_clr_s = 2'b00;
    other_mask_s  = rd_bank_q ? 2'b01 : 2'b10;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != 2'b00) begin
          state_d   = ST_READ;
          rd_pos_d  = 6'd0;
          rd_bank_d = pending_q[0] ? 1'b0 : 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_en_s = 1'b1;
        if (rd_pos_q == LAST_POS) begin
          pending_clr_s = rd_bank_q ? 2'b10 : 2'b01;
          rd_pos_d      = 6'd0;
          if (((pending_q | pending_set_s) & other_mask_s) != 2'b00) begin
            state_d   = ST_READ;
            rd_bank_d = ~rd_bank_q;
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          rd_pos_d = rd_pos_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pending_d = (pending_q & ~pending_clr_s) | pending_set_s;
    raddr_s   = {rd_bank_q, rd_pos_q};
  end

  // Output sideband aligned with the RAM's registered read data
  always_comb begin
    out_d.valid = rd_en_s;
    out_d.last  = rd_en_s && (rd_pos_q == LAST_POS);
    out_d.pos   = rd_en_s ? rd_pos_q : out_q.pos;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_k_q    <= 6'd0;
      wr_bank_q <= 1'b0;
      pending_q <= 2'b00;
      state_q   <= ST_IDLE;
      rd_pos_q  <= 6'd0;
      rd_bank_q <= 1'b0;
      out_q     <= '0;
    end else begin
      wr_k_q    <= wr_k_d;
      wr_bank_q <= wr_bank_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      rd_pos_q  <= rd_pos_d;
      rd_bank_q <= rd_bank_d;
      out_q     <= out_d;
    end
  end

  izz_bank_ram #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en_s),
    .waddr(waddr_s),
    .wdata(in_data),
    .re   (rd_en_s),
    .raddr(raddr_s),
    .rdata(out_data)
  );

  assign out_valid = out_q.valid;
  assign out_last  = out_q.last;
  assign out_pos   = out_q.pos;

endmodule
